// File: rtl/hcsr04_echo_emulator_periph.sv
// HC-SR04 responder emulator on APB: answers a valid trig_in pulse with a programmable echo pulse.
// Registers: CTRL (EN, NO_TARGET), DIST (cm), STATUS (BUSY, SHORT_TRIG W1C, PING_CNT).
module hcsr04_echo_emulator_periph #(
  parameter int unsigned CLK_PER_US   = 100,
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned NO_TARGET_US = 38000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        trig_in,
  output logic        echo_out
);

  localparam int unsigned TICK_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRIG  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_ECHO  = 2'd3;

  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_trig_meta;
  logic              r_trig_s;
  logic              r_trig_prev;
  logic [1:0]        r_state;
  logic [15:0]       r_us_cnt;
  logic [15:0]       r_len;
  logic [8:0]        r_dist_q;
  logic              r_nt_q;
  logic              r_en;
  logic              r_no_target;
  logic [8:0]        r_dist;
  logic              r_short_trig;
  logic [7:0]        r_ping_cnt;
  logic              r_echo;
  logic [31:0]       r_prdata;
  logic              r_pready;

  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic        w_access;
  logic        w_wr;
  logic [1:0]  w_sel;
  logic        w_busy;
  logic        w_short_set;
  logic        w_short_clr;
  logic [15:0] w_len_calc;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_tick   = (r_tick_cnt == TICK_W'(CLK_PER_US - 1));
  assign w_rise   = r_trig_s & ~r_trig_prev;
  assign w_fall   = ~r_trig_s & r_trig_prev;
  assign w_access = PSEL & PENABLE & ~r_pready;
  assign w_wr     = w_access & PWRITE;
  assign w_sel    = PADDR[3:2];
  assign w_busy   = (r_state == ST_BURST) || (r_state == ST_ECHO);

  assign w_short_set = r_en && (r_state == ST_TRIG) && w_fall &&
                       (r_us_cnt < 16'(MIN_TRIG_US));
  assign w_short_clr = w_wr && (w_sel == 2'd2) && PWDATA[1];

  assign w_unused_bits = ^{PADDR[1:0], PWDATA[31:9]};

  // Product is kept to 16 bits; 511 cm * 58 us/cm still fits.
  always_comb begin
    w_len_calc = r_nt_q ? 16'(NO_TARGET_US) : (16'(r_dist_q) * 16'(US_PER_CM));
    if (w_len_calc == 16'd0) begin
      w_len_calc = 16'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      2'd0: w_rdata[1:0] = {r_no_target, r_en};
      2'd1: w_rdata[8:0] = r_dist;
      2'd2: begin
        w_rdata[0]    = w_busy;
        w_rdata[1]    = r_short_trig;
        w_rdata[15:8] = r_ping_cnt;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tick_cnt  <= '0;
      r_trig_meta <= 1'b0;
      r_trig_s    <= 1'b0;
      r_trig_prev <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_trig_meta <= trig_in;
      r_trig_s    <= r_trig_meta;
      r_trig_prev <= r_trig_s;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pready     <= 1'b0;
      r_prdata     <= '0;
      r_en         <= 1'b0;
      r_no_target  <= 1'b0;
      r_dist       <= '0;
      r_short_trig <= 1'b0;
    end else begin
      r_pready <= w_access;
      if (w_access && !PWRITE) begin
        r_prdata <= w_rdata;
      end
      if (w_wr && (w_sel == 2'd0)) begin
        r_en        <= PWDATA[0];
        r_no_target <= PWDATA[1];
      end
      if (w_wr && (w_sel == 2'd1)) begin
        r_dist <= PWDATA[8:0];
      end
      // A new short trigger outranks a simultaneous W1C.
      r_short_trig <= w_short_set | (r_short_trig & ~w_short_clr);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= ST_IDLE;
      r_us_cnt   <= '0;
      r_len      <= '0;
      r_dist_q   <= '0;
      r_nt_q     <= 1'b0;
      r_ping_cnt <= '0;
      r_echo     <= 1'b0;
    end else if (!r_en) begin
      r_state <= ST_IDLE;
      r_echo  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_echo <= 1'b0;
          if (w_rise) begin
            r_state  <= ST_TRIG;
            r_us_cnt <= '0;
          end
        end
        ST_TRIG: begin
          if (w_fall) begin
            if (r_us_cnt >= 16'(MIN_TRIG_US)) begin
              // Snapshot so register writes cannot disturb the ping in flight.
              r_dist_q <= r_dist;
              r_nt_q   <= r_no_target;
              r_us_cnt <= '0;
              r_state  <= ST_BURST;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_tick && (r_us_cnt != 16'hFFFF)) begin
            r_us_cnt <= r_us_cnt + 16'd1;
          end
        end
        ST_BURST: begin
          if (w_tick) begin
            if (r_us_cnt == 16'(BURST_US - 1)) begin
              r_echo   <= 1'b1;
              r_len    <= w_len_calc;
              r_us_cnt <= '0;
              r_state  <= ST_ECHO;
            end else begin
              r_us_cnt <= r_us_cnt + 16'd1;
            end
          end
        end
        ST_ECHO: begin
          if (w_tick) begin
            if (r_us_cnt == r_len - 16'd1) begin
              r_echo     <= 1'b0;
              r_ping_cnt <= r_ping_cnt + 8'd1;
              r_state    <= ST_IDLE;
            end else begin
              r_us_cnt <= r_us_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign echo_out = r_echo;

endmodule

// File: tb/tb_hcsr04_echo_emulator_periph.sv
// Directed bench for the HC-SR04 echo emulator, scaled timing parameters for short runs.
module tb_hcsr04_echo_emulator_periph;

  localparam int unsigned C     = 2;
  localparam int unsigned MINT  = 10;
  localparam int unsigned BURST = 20;
  localparam int unsigned UPC   = 58;
  localparam int unsigned NT    = 1000;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        trig_in = 1'b0;
  logic        echo_out;

  int n_vec = 0;
  int n_bad = 0;
  int hi_cnt = 0;
  int rise_cnt = 0;
  logic echo_prev = 1'b0;

  hcsr04_echo_emulator_periph #(
    .CLK_PER_US  (C),
    .MIN_TRIG_US (MINT),
    .BURST_US    (BURST),
    .US_PER_CM   (UPC),
    .NO_TARGET_US(NT)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .trig_in (trig_in),
    .echo_out(echo_out)
  );

  always #5 PCLK = ~PCLK;

  // Cycles with echo high before each edge, and rising edges seen.
  always @(posedge PCLK) begin
    if (echo_out) hi_cnt = hi_cnt + 1;
    if (echo_out && !echo_prev) rise_cnt = rise_cnt + 1;
    echo_prev = echo_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    do begin
      @(posedge PCLK); #1;
      k = k + 1;
    end while (!PREADY && k < 10);
    if (!PREADY) check(tag, {31'd0, PREADY}, 32'd1);
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    wait_ready("apb_write_timeout");
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    wait_ready("apb_read_timeout");
    check(tag, PRDATA, exp);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_trig(input int us);
    @(posedge PCLK); #1;
    trig_in = 1'b1;
    repeat (us * C) @(posedge PCLK);
    #1 trig_in = 1'b0;
  endtask

  task automatic wait_rise(input string tag, output int d);
    d = 0;
    while (!echo_out && d < (BURST + 2) * C + 20) begin
      @(posedge PCLK); #1;
      d = d + 1;
    end
    if (!echo_out) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_fall(input string tag, input int limit);
    int k;
    k = 0;
    while (echo_out && k < limit) begin
      @(posedge PCLK); #1;
      k = k + 1;
    end
    if (echo_out) check(tag, 32'd1, 32'd0);
  endtask

  initial begin
    int d;
    int hb;
    int rb;

    repeat (3) @(posedge PCLK);
    #1;
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_echo", {31'd0, echo_out}, 32'd0);
    PRESET = 1'b0;
    read_check("rst_ctrl", 4'h0, 32'd0);
    read_check("rst_dist", 4'h4, 32'd0);
    read_check("rst_status", 4'h8, 32'd0);

    // Register map basics.
    apb_write(4'h4, 32'hFFFF_FFFF);
    read_check("dist_mask", 4'h4, 32'h1FF);
    apb_write(4'hC, 32'hFFFF_FFFF);
    read_check("reserved", 4'hC, 32'd0);

    // Disabled: trigger ignored.
    rb = rise_cnt;
    pulse_trig(12);
    repeat (BURST * C + 40) @(posedge PCLK);
    #1 check("dis_no_echo", 32'(rise_cnt - rb), 32'd0);

    // Nominal ping, DIST=100.
    apb_write(4'h4, 32'd100);
    apb_write(4'h0, 32'd1);
    read_check("ctrl_rb", 4'h0, 32'd1);
    hb = hi_cnt; rb = rise_cnt;
    pulse_trig(12);
    wait_rise("p1_rise_timeout", d);
    check("p1_delay", {31'd0, (d >= (BURST - 1) * C + 4) && (d <= BURST * C + 3)}, 32'd1);
    read_check("p1_busy", 4'h8, 32'h001);
    wait_fall("p1_fall_timeout", 100 * UPC * C + 50);
    check("p1_width", 32'(hi_cnt - hb), 32'(100 * UPC * C));
    check("p1_rises", 32'(rise_cnt - rb), 32'd1);
    read_check("p1_status", 4'h8, 32'h100);

    // Short trigger sets the sticky flag, W1C clears it.
    rb = rise_cnt;
    pulse_trig(5);
    repeat (BURST * C + 40) @(posedge PCLK);
    #1 check("short_no_echo", 32'(rise_cnt - rb), 32'd0);
    read_check("short_status", 4'h8, 32'h102);
    apb_write(4'h8, 32'h2);
    read_check("short_w1c", 4'h8, 32'h100);

    // NO_TARGET echo.
    apb_write(4'h0, 32'd3);
    hb = hi_cnt;
    pulse_trig(12);
    wait_rise("nt_rise_timeout", d);
    wait_fall("nt_fall_timeout", NT * C + 50);
    check("nt_width", 32'(hi_cnt - hb), 32'(NT * C));
    read_check("nt_status", 4'h8, 32'h200);

    // DIST=0 is forced to a 1 us echo.
    apb_write(4'h4, 32'd0);
    apb_write(4'h0, 32'd1);
    hb = hi_cnt;
    pulse_trig(12);
    wait_rise("d0_rise_timeout", d);
    wait_fall("d0_fall_timeout", 50);
    check("d0_width", 32'(hi_cnt - hb), 32'(C));
    read_check("d0_status", 4'h8, 32'h300);

    // Writes and a trigger during the echo do not disturb it.
    apb_write(4'h4, 32'd20);
    hb = hi_cnt; rb = rise_cnt;
    pulse_trig(12);
    wait_rise("mid_rise_timeout", d);
    apb_write(4'h4, 32'd300);
    apb_write(4'h0, 32'd3);
    pulse_trig(12);
    wait_fall("mid_fall_timeout", 20 * UPC * C + 50);
    check("mid_width", 32'(hi_cnt - hb), 32'(20 * UPC * C));
    check("mid_rises", 32'(rise_cnt - rb), 32'd1);
    repeat (BURST * C + 40) @(posedge PCLK);
    #1 check("mid_no_queue", 32'(rise_cnt - rb), 32'd1);
    read_check("mid_status", 4'h8, 32'h400);
    read_check("mid_dist", 4'h4, 32'd300);

    // Clearing EN aborts the echo without counting it.
    apb_write(4'h4, 32'd20);
    apb_write(4'h0, 32'd1);
    pulse_trig(12);
    wait_rise("en_rise_timeout", d);
    repeat (50) @(posedge PCLK);
    apb_write(4'h0, 32'd0);
    @(posedge PCLK); #1;
    check("en_echo_low", {31'd0, echo_out}, 32'd0);
    read_check("en_status", 4'h8, 32'h400);

    // Reset mid-ping.
    apb_write(4'h0, 32'd1);
    pulse_trig(12);
    wait_rise("rst_rise_timeout", d);
    repeat (20) @(posedge PCLK);
    #1 PRESET = 1'b1;
    #1 check("rst_mid_echo", {31'd0, echo_out}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    read_check("rst2_ctrl", 4'h0, 32'd0);
    read_check("rst2_dist", 4'h4, 32'd0);
    read_check("rst2_status", 4'h8, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
